// File: rtl/serial_mag_comp_accum.sv
// -----------------------------------------------------------------------------
// serial_mag_comp_accum
//
// Folds the per-slice greater/equal/less outputs of a 2-bit magnitude
// comparator into one verdict for a wide word. Slices arrive one per cycle,
// most-significant first. A single comparator can then be time-multiplexed
// across the slices of a wide operand.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : a slice code is present on c0/c1/c2 this cycle
//   in_first  : with in_valid, the slice is the MS slice of a new word
//   in_last   : with in_valid, the slice is the LS slice of the word
//   c0/c1/c2  : slice A>B / A==B / A<B
//   out_valid : one-cycle pulse, the result outputs hold a new word result
//   gt/eq/lt  : word verdict (all zero when err is set)
//   err       : word result invalid (bad slice code or too many slices)
//   nslices   : slices accepted in the reported word, saturating at MAX+1
//   busy      : a word is in progress
// -----------------------------------------------------------------------------
module serial_mag_comp_accum #(
   parameter int MAX_SLICES = 8,
   parameter int CNTW       = $clog2(MAX_SLICES + 2)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic            in_first,
   input  logic            in_last,
   input  logic            c0,
   input  logic            c1,
   input  logic            c2,
   output logic            out_valid,
   output logic            gt,
   output logic            eq,
   output logic            lt,
   output logic            err,
   output logic [CNTW-1:0] nslices,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, EQUAL, DECIDED} state_t;

   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_SLICES);
   localparam logic [CNTW-1:0] CNT_SAT = CNTW'(MAX_SLICES + 1);

   state_t          state_q, state_d, base_state, word_state;
   logic [CNTW-1:0] cnt_q, cnt_d, base_cnt;
   logic            err_q, err_d, base_err;
   logic            vgt_q, vgt_d;     // latched verdict in DECIDED: 1 = gt, 0 = lt
   logic            accept, code_ok, emit;

   logic            ov_q, gt_q, eq_q, lt_q, oerr_q;
   logic [CNTW-1:0] ns_q;

   always_comb begin
      accept = in_valid & (in_first | (state_q != IDLE));

      case ({c0, c1, c2})
         3'b100, 3'b010, 3'b001: code_ok = 1'b1;
         default:                code_ok = 1'b0;
      endcase

      // in_first discards the word in progress and restarts from a clean slate
      base_state = in_first ? EQUAL : state_q;
      base_cnt   = in_first ? '0    : cnt_q;
      base_err   = in_first ? 1'b0  : err_q;

      state_d    = state_q;
      word_state = state_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      vgt_d      = vgt_q;
      emit       = 1'b0;

      if (accept) begin
         cnt_d      = (base_cnt == CNT_SAT) ? base_cnt : base_cnt + 1'b1;
         err_d      = base_err | ~code_ok | (cnt_d > CNT_MAX);
         vgt_d      = in_first ? 1'b0 : vgt_q;
         word_state = base_state;

         // an invalid code is treated as equal, so it can never decide
         if (base_state == EQUAL && code_ok && c0) begin
            word_state = DECIDED;
            vgt_d      = 1'b1;
         end else if (base_state == EQUAL && code_ok && c2) begin
            word_state = DECIDED;
            vgt_d      = 1'b0;
         end

         state_d = in_last ? IDLE : word_state;
         emit    = in_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         vgt_q   <= 1'b0;
         ov_q    <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         oerr_q  <= 1'b0;
         ns_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         vgt_q   <= vgt_d;
         ov_q    <= emit;
         if (emit) begin
            gt_q   <= ~err_d & (word_state == DECIDED) &  vgt_d;
            lt_q   <= ~err_d & (word_state == DECIDED) & ~vgt_d;
            eq_q   <= ~err_d & (word_state == EQUAL);
            oerr_q <= err_d;
            ns_q   <= cnt_d;
         end
      end
   end

   assign out_valid = ov_q;
   assign gt        = gt_q;
   assign eq        = eq_q;
   assign lt        = lt_q;
   assign err       = oerr_q;
   assign nslices   = ns_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: doc/serial_mag_comp_accum.md
# serial_mag_comp_accum

Sequential word comparator that sits directly downstream of the 2-bit magnitude comparator. It consumes that comparator's per-slice greater/equal/less outputs one 2-bit slice per cycle, most-significant slice first. It reduces them into a single greater/equal/less verdict for an operand of up to MAX_SLICES slices. Callers can therefore compare wide operands with one 2-bit comparator instance time-multiplexed over the slices.

## Interface
Parameters:
- MAX_SLICES, 8, maximum number of 2-bit slices per word (8 = 16-bit operands); legal range 1..64
- CNTW, $clog2(MAX_SLICES+2), width of the slice counter and of nslices

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  slice code on c0/c1/c2 is present this cycle
- in_first  input  1  qualifies in_valid: slice is the most-significant slice of a new word
- in_last  input  1  qualifies in_valid: slice is the least-significant slice of the word
- c0  input  1  slice A>B (comparator greater output)
- c1  input  1  slice A==B (comparator equal output)
- c2  input  1  slice A<B (comparator less output)
- out_valid  output  1  one-cycle pulse: gt/eq/lt/err/nslices hold a new word result
- gt  output  1  word A>B
- eq  output  1  word A==B
- lt  output  1  word A<B
- err  output  1  word result invalid
- nslices  output  CNTW  number of slices accepted in the reported word, saturating at MAX_SLICES+1
- busy  output  1  a word is in progress (state not IDLE)

## Operation
- States: IDLE, EQUAL (all slices so far equal), DECIDED (verdict latched).
- Slice accepted when in_valid=1 and either in_first=1 or state!=IDLE.
- in_valid=1, in_first=0, state IDLE: slice ignored; no state change, no output.
- in_first=1 in any state: aborts any word in progress without output, clears counter/err/verdict, and evaluates this slice as slice 1.
- Slice evaluation:
  - Code valid iff exactly one of c0,c1,c2 is 1; otherwise set word err and treat the slice as equal.
  - EQUAL + c0 -> DECIDED with verdict gt.
  - EQUAL + c2 -> DECIDED with verdict lt.
  - EQUAL + c1 -> stay EQUAL.
  - DECIDED: verdict frozen; later slices are still counted and validity-checked.
- Counter increments per accepted slice and saturates at MAX_SLICES+1; count > MAX_SLICES sets word err.
- in_last on an accepted slice:
  - Registers the result: verdict (EQUAL -> eq).
  - If err, gt=eq=lt=0 and err=1.
  - out_valid=1 for one cycle; state returns to IDLE.
- in_first=1 and in_last=1 together: single-slice word.
- in_last=1 with in_valid=0: ignored.
- gt/eq/lt/err/nslices hold their last reported values until the next result; exactly one of gt/eq/lt is 1 when err=0.
- in_valid low inside a word is a stall; no timeout.

## Timing
- Reset (rst_n=0, asynchronous): state IDLE, out_valid=0, gt=0, eq=0, lt=0, err=0, nslices=0, busy=0; any word in progress is discarded.
- Reset release is sampled synchronously at the next clk edge.
- Latency: slice with in_last accepted at edge t -> out_valid=1 and result visible after edge t, for cycle t..t+1 only.
- busy=1 from the edge accepting in_first until the edge accepting in_last; it falls in the same cycle out_valid rises.
- Throughput: one slice per cycle. Back-to-back words are allowed: in_first may be accepted the cycle after in_last with no bubble, and out_valid for word N overlaps slice 1 of word N+1.
- No inputs are combinationally passed to outputs; all outputs are registered.

## Test plan
- Reset mid-word: start a word with slice c1=1, then pull rst_n low asynchronously between edges -> all outputs 0 immediately, busy=0; the following in_first word reports normally.
- Equal word, 4 slices of c1=1, first/last on slices 1/4 -> one cycle after slice 4: out_valid=1, eq=1, gt=lt=0, err=0, nslices=4.
- Early decision: slices (c1),(c0),(c2),(c1) -> gt=1, nslices=4; and slices (c2),(c0) -> lt=1, nslices=2.
- Stall and abort: slices (c1),stall 3 cycles,(c2),then in_first (c0)+in_last -> single out_valid with gt=1, nslices=1; the aborted word produces no out_valid.
- Errors:
  - Invalid code (c0=c2=1) in slice 2 of 3 -> err=1, gt=eq=lt=0.
  - MAX_SLICES+1 equal slices -> err=1, nslices=MAX_SLICES+1.
  - Stray slice in IDLE without in_first -> no output.
- Back-to-back single-slice words (c0),(c2),(c1), each with in_first=in_last=1 on consecutive cycles -> out_valid high three consecutive cycles reporting gt, lt, eq in order.
